// File: rtl/memory_system_hs.sv
// Single-port word memory with valid/ready request/response handshake.
// Optional access checking via `MEM_ERROR_CHECK_EN (off by default).
module memory_system_hs #(
  parameter int    MEMORY_DEPTH = 32,
  parameter int    DATA_WIDTH   = 32,
  parameter string INIT_FILE    = ""
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_we_i,
  input  logic [DATA_WIDTH/8-1:0] req_be_i,
  input  logic [DATA_WIDTH-1:0]   address_i,
  input  logic [DATA_WIDTH-1:0]   write_data,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   read_data_o,
  output logic                    rsp_error_o
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(MEMORY_DEPTH);

  typedef enum logic {
    EMPTY,
    FULL
  } state_t;

  state_t state, state_n;

  logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic [IDX_W-1:0]      idx;
  logic                  accept;
  logic                  req_err;
  logic                  wr_en;

  assign idx = address_i[OFF_W +: IDX_W];

`ifdef MEM_ERROR_CHECK_EN
  localparam int HI = OFF_W + IDX_W;
  localparam logic [DATA_WIDTH-1:0] OFF_MASK =
    DATA_WIDTH'(BYTES - 1);

  assign req_err = (|(address_i & OFF_MASK))
                 | (|(address_i >> HI));
`else
  logic unused_addr;

  // Offset and upper bits are dropped: addresses wrap.
  assign unused_addr = ^address_i;
  assign req_err     = 1'b0;
`endif

  // Ready is forced high during reset so nothing stalls there.
  assign req_ready_o = ~reset_n | ~rsp_valid_o | rsp_ready_i;
  assign accept      = reset_n & req_valid_i & req_ready_o;
  assign wr_en       = accept & req_we_i & ~req_err;

  assign rsp_valid_o = (state == FULL);
  assign read_data_o = rdata_q;
  assign rsp_error_o = err_q;

  always_comb begin
    state_n = state;
    unique case (state)
      EMPTY: if (accept) state_n = FULL;
      FULL: begin
        if (accept)           state_n = FULL;
        else if (rsp_ready_i) state_n = EMPTY;
      end
      default: state_n = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= EMPTY;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        rdata_q <= (req_we_i | req_err) ? '0 : mem[idx];
        err_q   <= req_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < BYTES; b++) begin
        if (req_be_i[b])
          mem[idx][8*b +: 8] <= write_data[8*b +: 8];
      end
    end
  end

endmodule
